serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes D = A - B one bit per clock using a single full-adder cell: inverted B operand, carry-in forced to 1 on bit 0.
- Area-lean sequential counterpart to the combinational adder chain. Feeds the ALU's multi-cycle path.
- Produces the difference plus borrow, overflow and zero flags.
- Uses a START/DONE handshake.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 2).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  reset, asynchronous, active-low
- START  input  1  request; sampled only when the block is idle or in the DONE state
- A  input  WIDTH  minuend; captured on the accepting edge
- B  input  WIDTH  subtrahend; captured on the accepting edge
- BUSY  output  1  high while the subtraction is in progress (RUN state)
- DONE  output  1  one-cycle completion pulse
- D  output  WIDTH  difference A - B, modulo 2^WIDTH
- BO  output  1  borrow out; 1 iff unsigned A < B
- V  output  1  signed overflow
- Z  output  1  1 iff D == 0

Behaviour:

Reset
- RST low asynchronously forces: state IDLE, BUSY=0, DONE=0, D=0, BO=0, V=0, Z=0, bit counter=0, internal operand/carry registers=0.
- Reset mid-operation discards the operation; no DONE is produced.
- Operation resumes on the first CLK edge after RST returns high.

States
- IDLE, RUN, FIN.

IDLE
- START=1 at an edge:
  - latch A into shift register SA and B into SB;
  - set carry=1 and counter=0;
  - go to RUN.
- START=0: stay in IDLE.

RUN (BUSY=1), each edge:
- sum = SA[0] ^ ~SB[0] ^ carry
- carry <= majority(SA[0], ~SB[0], carry)
- sum is shifted into the result shift register from the MSB side (LSB-first accumulation)
- SA and SB shift right; counter increments.
- On the edge that processes bit WIDTH-1, go to FIN and register outputs:
  - D = final result;
  - BO = ~final carry;
  - V = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched MSBs;
  - Z = (D == 0).

FIN
- DONE=1 for exactly this one cycle; BUSY=0.
- Next edge: START=1 re-accepts (back-to-back operation, straight into RUN with new operands); otherwise go to IDLE.

Latency
- START accepted at edge t.
- DONE is high during the cycle following edge t+WIDTH.
- Throughput: one result per WIDTH+1 cycles.

Output holding
- D, BO, V and Z change only on the FIN-entry edge or on reset.
- They hold the previous result throughout IDLE and RUN.

Input rules
- START is ignored while in RUN.
- A and B changes after the accepting edge have no effect.

Width rules
- D wraps modulo 2^WIDTH.
- No saturation.
- Flags are computed on the full WIDTH bits.

Test Plan:
1. WIDTH=32, A=10, B=3, START pulse -> DONE high exactly in the cycle after the 32nd edge past acceptance; D=7, BO=0, V=0, Z=0; BUSY high for 32 cycles.
2. A=3, B=10 -> D=0xFFFFFFF9, BO=1, V=0, Z=0.
3. A=0x80000000, B=1 -> D=0x7FFFFFFF, V=1, BO=0; A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, V=1, BO=1.
4. A=B=0x00001234 -> D=0, Z=1, BO=0, V=0; A=0, B=0 -> Z=1.
5. Handshake checks:
   - START held high and A/B changed during RUN -> result reflects the original operands and only one DONE is produced.
   - START=1 during the FIN cycle with A=5, B=5 -> RUN entered immediately, next DONE exactly WIDTH+1 cycles later, Z=1.
6. RST driven low asynchronously, mid-clock, 10 cycles into a run -> all outputs 0 immediately with no DONE; after release, A=100, B=1 -> D=99 with correct latency.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor, D = A - B, one bit per clock.
//   It uses a single full-adder cell. The adder sees the inverted B bit, and
//   its carry is preset to 1, so it forms A + ~B + 1.
//   Operands are accepted with a START/DONE handshake. The difference and its
//   flags are registered once, when the operation finishes.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for START; the last result is held on D/BO/V/Z
//   RUN   | one operand bit is processed per edge, LSB first; BUSY=1
//   FIN   | result valid; DONE=1 for this cycle only; START may re-accept
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-low reset
//   START  in   request; sampled only in IDLE or FIN
//   A, B   in   minuend / subtrahend, captured on the accepting edge
//   BUSY   out  high while in RUN
//   DONE   out  one-cycle completion pulse (FIN)
//   D      out  A - B modulo 2^WIDTH
//   BO     out  borrow out; 1 iff unsigned A < B
//   V      out  signed overflow
//   Z      out  1 iff D == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             nb;
  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  // Full-adder cell on the current LSBs, with the subtrahend bit inverted.
  always_comb begin
    nb      = ~sb_q[0];
    sum_d   = sa_q[0] ^ nb ^ carry_q;
    carry_d = (sa_q[0] & nb) | (sa_q[0] & carry_q) | (nb & carry_q);
    // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
    // difference has reached position 0.
    res_d   = {sum_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      D       <= '0;
      BO      <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          DONE <= 1'b0;
          if (START) begin
            sa_q    <= A;
            sb_q    <= B;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
            carry_q <= 1'b1;
            cnt_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= S_RUN;
          end else begin
            BUSY    <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= S_FIN;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            D       <= res_d;
            // A carry out of A + ~B + 1 means that no borrow occurred.
            BO      <= ~carry_d;
            // Overflow can occur only when the operand signs differ and the
            // result sign differs from the minuend sign.
            V       <= (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
            Z       <= ~|res_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule
